// File: rtl/l1_cache_tag_array.sv
// N-way set-associative L1 tag store: parallel lookup, invalidation sweep, write forwarding, multi-hit flag.
// Define L1_TAG_PLRU_EN for per-set tree pseudo-LRU victim selection; otherwise a global round-robin is used.
module l1_cache_tag_array #(
    parameter  int NUM_WAYS   = 4,
    parameter  int NUM_SETS   = 64,
    parameter  int ADDR_WIDTH = 26,
    localparam int SET_W      = $clog2(NUM_SETS),
    localparam int WAY_W      = $clog2(NUM_WAYS),
    localparam int TAG_W      = ADDR_WIDTH - SET_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] request_addr,
    input  logic                  access_i,
    output logic                  hit_o,
    output logic [WAY_W-1:0]      hit_way_o,
    output logic                  multi_hit_o,
    input  logic                  update_i,
    input  logic                  invalidate_i,
    input  logic [WAY_W-1:0]      update_way_i,
    input  logic [SET_W-1:0]      update_set_i,
    input  logic [TAG_W-1:0]      update_tag_i,
    input  logic                  flush_i,
    output logic                  ready_o,
    output logic [WAY_W-1:0]      victim_way_o
);

    localparam logic [0:0] ST_SWEEP = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]          state;
    logic [SET_W-1:0]    sweep_cnt;
    logic                access_q;
    logic [TAG_W-1:0]    tag_q;
    logic [SET_W-1:0]    set_q;
    logic                ready;
    logic                wr_en;
    logic                upd_en;
    logic [NUM_WAYS-1:0] match;

    logic [NUM_SETS-1:0] valid_mem [NUM_WAYS];
    logic [TAG_W-1:0]    tag_mem   [NUM_WAYS][NUM_SETS];

    assign ready   = (state == ST_READY);
    assign ready_o = ready;
    assign wr_en   = ready && (update_i || invalidate_i);
    assign upd_en  = ready && update_i && !invalidate_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_SWEEP;
            sweep_cnt <= '0;
            access_q  <= 1'b0;
            tag_q     <= '0;
            set_q     <= '0;
        end else begin
            access_q <= access_i && ready;
            if (access_i && ready) begin
                tag_q <= request_addr[ADDR_WIDTH-1:SET_W];
                set_q <= request_addr[SET_W-1:0];
            end
            case (state)
                ST_SWEEP: begin
                    if (flush_i) begin
                        sweep_cnt <= '0;
                    end else begin
                        sweep_cnt <= sweep_cnt + 1'b1;
                        if (sweep_cnt == SET_W'(NUM_SETS - 1)) state <= ST_READY;
                    end
                end
                default: begin
                    if (flush_i) begin
                        state     <= ST_SWEEP;
                        sweep_cnt <= '0;
                    end
                end
            endcase
        end
    end

    // Array holds no reset; the sweep that follows every reset clears the valid bits.
    always_ff @(posedge clk) begin
        if (!ready) begin
            for (int unsigned w = 0; w < NUM_WAYS; w++) valid_mem[w][sweep_cnt] <= 1'b0;
        end else if (wr_en) begin
            valid_mem[update_way_i][update_set_i] <= upd_en;
            tag_mem[update_way_i][update_set_i]   <= update_tag_i;
        end
    end

    // Compare against the latched set after the write edge, so same-cycle writes forward naturally.
    always_comb begin
        match     = '0;
        hit_way_o = '0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            match[w] = valid_mem[w][set_q] && (tag_mem[w][set_q] == tag_q);
        end
        for (int unsigned i = 0; i < NUM_WAYS; i++) begin
            if (match[NUM_WAYS-1-i]) hit_way_o = WAY_W'(NUM_WAYS - 1 - i);
        end
    end

    assign hit_o       = access_q && ready && (|match);
    assign multi_hit_o = access_q && ready && ($countones(match) > 1);

`ifdef L1_TAG_PLRU_EN
    logic [NUM_WAYS-2:0] plru_mem [NUM_SETS];

    // Tree node n (1-based heap order) stores the direction of the next victim: 0 = left, 1 = right.
    function automatic logic [NUM_WAYS-2:0] plru_touch(input logic [NUM_WAYS-2:0] bits,
                                                       input logic [WAY_W-1:0]    way);
        logic [NUM_WAYS-2:0] r;
        int unsigned         node;
        logic                dir;
        r    = bits;
        node = 1;
        for (int unsigned l = 0; l < WAY_W; l++) begin
            dir         = way[WAY_W-1-l];
            r[node-1]   = ~dir;
            node        = 2 * node + (dir ? 1 : 0);
        end
        return r;
    endfunction

    always_comb begin
        int unsigned node;
        logic        b;
        node         = 1;
        victim_way_o = '0;
        for (int unsigned l = 0; l < WAY_W; l++) begin
            b            = plru_mem[set_q][node-1];
            victim_way_o = (victim_way_o << 1) | WAY_W'(b);
            node         = 2 * node + (b ? 1 : 0);
        end
    end

    always_ff @(posedge clk) begin
        if (!ready) begin
            plru_mem[sweep_cnt] <= '0;
        end else begin
            if (hit_o) plru_mem[set_q] <= plru_touch(plru_mem[set_q], hit_way_o);
            if (upd_en) plru_mem[update_set_i] <= plru_touch(plru_mem[update_set_i], update_way_i);
        end
    end
`else
    logic [WAY_W-1:0] rr_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rr_cnt <= '0;
        else if (upd_en) rr_cnt <= rr_cnt + 1'b1;
    end

    assign victim_way_o = rr_cnt;
`endif

    a_upd_inv_excl: assert property (@(posedge clk) disable iff (reset) !(update_i && invalidate_i));

endmodule

// File: tb/tb_l1_cache_tag_array.sv
// Self-checking bench for l1_cache_tag_array: directed vector table, sweep/flush sequences, random vs. array model.
module tb_l1_cache_tag_array;

    localparam int NW = 4;
    localparam int NS = 64;
    localparam int AW = 26;
    localparam int SW = 6;
    localparam int WW = 2;
    localparam int TW = AW - SW;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] request_addr;
    logic          access_i;
    logic          hit_o;
    logic [WW-1:0] hit_way_o;
    logic          multi_hit_o;
    logic          update_i;
    logic          invalidate_i;
    logic [WW-1:0] update_way_i;
    logic [SW-1:0] update_set_i;
    logic [TW-1:0] update_tag_i;
    logic          flush_i;
    logic          ready_o;
    logic [WW-1:0] victim_way_o;

    l1_cache_tag_array #(.NUM_WAYS(NW), .NUM_SETS(NS), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .request_addr(request_addr), .access_i(access_i),
        .hit_o(hit_o), .hit_way_o(hit_way_o), .multi_hit_o(multi_hit_o),
        .update_i(update_i), .invalidate_i(invalidate_i), .update_way_i(update_way_i),
        .update_set_i(update_set_i), .update_tag_i(update_tag_i), .flush_i(flush_i),
        .ready_o(ready_o), .victim_way_o(victim_way_o)
    );

    always #5 clk = ~clk;

    int nchecks = 0;
    int nerr    = 0;

    // Reference model: plain arrays of valid/tag per (way, set) plus an update counter.
    bit mv [NW][NS];
    int mt [NW][NS];
    int nupd = 0;
    int e_hit, e_way, e_multi;

    typedef struct {
        logic upd;
        logic inv;
        int   way;
        int   set;
        int   tag;
        logic acc;
        int   atag;
        int   aset;
        int   x_hit;
        int   x_way;
        int   x_multi;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string name, input int act, input int exp);
        nchecks++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int w = 0; w < NW; w++)
            for (int s = 0; s < NS; s++) mv[w][s] = 1'b0;
    endtask

    // One clock: drive inputs, take the edge, sample 1 time unit later; optionally advance the model.
    task automatic cycle(input logic upd, input logic inv, input int way, input int set, input int tg,
                         input logic acc, input int atag, input int aset, input logic model_on);
        int cnt;
        update_i     = upd;
        invalidate_i = inv;
        update_way_i = WW'(way);
        update_set_i = SW'(set);
        update_tag_i = TW'(tg);
        access_i     = acc;
        request_addr = {TW'(atag), SW'(aset)};
        @(posedge clk);
        #1;
        update_i     = 1'b0;
        invalidate_i = 1'b0;
        access_i     = 1'b0;
        flush_i      = 1'b0;
        if (model_on) begin
            if (inv) mv[way][set] = 1'b0;
            else if (upd) begin
                mv[way][set] = 1'b1;
                mt[way][set] = tg;
                nupd++;
            end
            e_hit = 0; e_way = 0; e_multi = 0; cnt = 0;
            if (acc) begin
                for (int w = NW - 1; w >= 0; w--)
                    if (mv[w][aset] && mt[w][aset] == atag) begin
                        cnt++;
                        e_way = w;
                    end
                e_hit   = (cnt > 0) ? 1 : 0;
                e_multi = (cnt > 1) ? 1 : 0;
            end
        end
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 0, 1'b1);
    endtask

    initial begin
        int low_cycles;
        int misses;
        int waited;

        vt[0] = '{1'b1, 1'b0, 2, 5, 'h1234, 1'b0, 0,       0, 0, 0, 0};
        vt[1] = '{1'b0, 1'b0, 0, 0, 0,      1'b1, 'h1234,  5, 1, 2, 0};
        vt[2] = '{1'b0, 1'b0, 0, 0, 0,      1'b1, 'h1235,  5, 0, 0, 0};
        vt[3] = '{1'b0, 1'b1, 2, 5, 'h1234, 1'b1, 'h1234,  5, 0, 0, 0};
        vt[4] = '{1'b1, 1'b0, 1, 7, 'h40,   1'b1, 'h40,    7, 1, 1, 0};
        vt[5] = '{1'b1, 1'b0, 0, 3, 'h99,   1'b0, 0,       0, 0, 0, 0};
        vt[6] = '{1'b1, 1'b0, 3, 3, 'h99,   1'b1, 'h99,    3, 1, 0, 1};
        vt[7] = '{1'b0, 1'b0, 0, 0, 0,      1'b1, 'h99,    3, 1, 0, 1};
        vt[8] = '{1'b0, 1'b1, 0, 3, 'h99,   1'b1, 'h99,    3, 1, 3, 0};
        vt[9] = '{1'b1, 1'b0, 2, 10, 'h5,   1'b1, 'h40,    7, 1, 1, 0};

        reset = 1'b1; access_i = 1'b0; update_i = 1'b0; invalidate_i = 1'b0; flush_i = 1'b0;
        update_way_i = '0; update_set_i = '0; update_tag_i = '0; request_addr = '0;
        model_clear();

        #1;
        chk("reset_hit", int'(hit_o), 0);
        chk("reset_multi", int'(multi_hit_o), 0);
        chk("reset_hit_way", int'(hit_way_o), 0);
        chk("reset_victim", int'(victim_way_o), 0);
        chk("reset_ready", int'(ready_o), 0);

        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        low_cycles = 0;
        for (int i = 0; i < NS; i++) begin
            if (!ready_o) low_cycles++;
            cycle(1'b0, 1'b0, 0, 0, 0, 1'b1, 0, 0, 1'b0);
            if (hit_o) low_cycles = -1000;
        end
        chk("sweep_low_cycles", low_cycles, NS);
        chk("sweep_ready_high", int'(ready_o), 1);

        misses = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b0, 0, 0, 0, 1'b1, $urandom_range(0, 255), i * 7, 1'b1);
            if (!hit_o) misses++;
        end
        chk("post_reset_all_miss", misses, 8);

        for (int i = 0; i < 10; i++) begin
            cycle(vt[i].upd, vt[i].inv, vt[i].way, vt[i].set, vt[i].tag,
                  vt[i].acc, vt[i].atag, vt[i].aset, 1'b1);
            chk($sformatf("vec%0d_hit", i), int'(hit_o), vt[i].x_hit);
            chk($sformatf("vec%0d_multi", i), int'(multi_hit_o), vt[i].x_multi);
            if (vt[i].x_hit != 0) chk($sformatf("vec%0d_way", i), int'(hit_way_o), vt[i].x_way);
        end
`ifndef L1_TAG_PLRU_EN
        chk("rr_after_5_updates", int'(victim_way_o), 1);
`endif

        for (int i = 0; i < 400; i++) begin
            int op;
            op = $urandom_range(0, 3);
            cycle(op == 0, op == 1, $urandom_range(0, NW - 1), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
            chk("rnd_hit", int'(hit_o), e_hit);
            chk("rnd_multi", int'(multi_hit_o), e_multi);
            if (e_hit != 0) chk("rnd_way", int'(hit_way_o), e_way);
`ifndef L1_TAG_PLRU_EN
            chk("rnd_victim", int'(victim_way_o), nupd % NW);
`endif
        end

        for (int s = 0; s < NS; s++) cycle(1'b1, 1'b0, 0, s, s + 1, 1'b0, 0, 0, 1'b1);
        cycle(1'b0, 1'b0, 0, 0, 0, 1'b1, 1, 0, 1'b1);
        chk("prefill_hit", int'(hit_o), 1);

        flush_i = 1'b1;
        cycle(1'b0, 1'b0, 0, 0, 0, 1'b1, 2, 1, 1'b0);
        chk("flush_ready_low", int'(ready_o), 0);
        chk("flush_cycle_access_hit", int'(hit_o), 0);
        cycle(1'b0, 1'b0, 0, 0, 0, 1'b1, 3, 2, 1'b0);
        chk("sweep_access_hit", int'(hit_o), 0);
        model_clear();
        waited = 0;
        while (!ready_o && waited < 2 * NS) begin
            idle();
            waited++;
        end
        chk("flush_sweep_len", waited + 1, NS);

        misses = 0;
        for (int s = 0; s < NS; s++) begin
            cycle(1'b0, 1'b0, 0, 0, 0, 1'b1, s + 1, s, 1'b1);
            if (!hit_o && e_hit == 0) misses++;
        end
        chk("post_flush_all_miss", misses, NS);

`ifdef L1_TAG_PLRU_EN
        for (int w = 0; w < NW; w++) cycle(1'b1, 1'b0, w, 9, 'h100 + w, 1'b0, 0, 0, 1'b1);
        cycle(1'b0, 1'b0, 0, 0, 0, 1'b1, 'h100, 9, 1'b1);
        chk("plru_hit_way0", int'(hit_way_o), 0);
        idle();
        chk("plru_victim", int'(victim_way_o), 2);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
